// File: rtl/loop_buffer_v2.sv
// Record/loop sample buffer: DEPTH-entry RAM read either as a consuming FIFO or
// as a cyclic, non-consuming loop, with a registered read port and sticky error flags.
module loop_buffer_v2 #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  clear,
  input  logic                  rewind,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] wr_ptr_dbg,
  output logic [ADDR_WIDTH-1:0] rd_ptr_dbg
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [ADDR_WIDTH-1:0] play_off;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  mode_q;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  pop;
  logic                  last_off;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign wr_ok    = wr_en && !full;
  assign rd_ok    = rd_en && !empty;
  assign pop      = rd_ok && !mode_q;
  // Pointer arithmetic is ADDR_WIDTH wide, so head+play_off wraps at DEPTH for free.
  assign rd_addr  = mode_q ? head + play_off : head;
  assign last_off = ({1'b0, play_off} == count - 1'b1);

  assign wr_ptr_dbg = tail;
  assign rd_ptr_dbg = rd_addr;

  // NOTE: the RAM is deliberately left out of reset so it maps onto block RAM;
  // stale contents are never visible because reads are gated by count.
  always_ff @(posedge clk) begin
    if (!rst && !clear && wr_ok) mem[tail] <= wr_data;
  end

  // NOTE: non-blocking assignments make the same-cycle read of mem[rd_addr]
  // return the word stored before this edge (read-before-write).
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head      <= '0;
      tail      <= '0;
      play_off  <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      mode_q    <= mode;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok)           rd_data   <= mem[rd_addr];
      if (wr_ok)           tail      <= tail + 1'b1;
      if (pop)             head      <= head + 1'b1;
      if (wr_en && full)   overflow  <= 1'b1;
      if (rd_en && empty)  underflow <= 1'b1;

      unique case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Mode change and rewind both restart the loop; the increment uses pre-cycle count.
      if (mode != mode_q) begin
        mode_q   <= mode;
        play_off <= '0;
      end else if (rewind) begin
        play_off <= '0;
      end else if (rd_ok && mode_q) begin
        play_off <= last_off ? '0 : play_off + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_loop_buffer_v2.sv
// Self-checking bench for loop_buffer_v2 (DEPTH=8): vector table, directed
// corner sequences, and randomized traffic against a queue-based model.
module tb_loop_buffer_v2;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic          clear = 1'b0;
  logic          rewind = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic [AW-1:0] wr_ptr_dbg;
  logic [AW-1:0] rd_ptr_dbg;

  int checks = 0;
  int errors = 0;

  loop_buffer_v2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mode(mode), .clear(clear), .rewind(rewind),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .underflow(underflow),
    .wr_ptr_dbg(wr_ptr_dbg), .rd_ptr_dbg(rd_ptr_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: stored words as a queue, loop position as an index into it.
  logic [DW-1:0] m_q[$];
  int            m_pos, m_head, m_tail;
  logic          m_mode, m_ovf, m_unf, m_rv;
  logic [DW-1:0] m_rd;

  function automatic void model_step();
    int n;
    logic do_rd;
    n = m_q.size();
    if (rst || clear) begin
      m_q.delete();
      m_pos = 0; m_head = 0; m_tail = 0;
      m_mode = mode; m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;
      return;
    end
    do_rd = rd_en && (n != 0);
    m_rv  = do_rd;
    if (rd_en && n == 0) m_unf = 1;
    if (do_rd) m_rd = m_mode ? m_q[m_pos] : m_q[0];
    if (do_rd && !m_mode) begin
      void'(m_q.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    if (mode != m_mode) begin
      m_mode = mode;
      m_pos  = 0;
    end else if (rewind) begin
      m_pos = 0;
    end else if (do_rd && m_mode) begin
      m_pos = (m_pos + 1) % n;
    end
    if (wr_en && n < DEPTH) begin
      m_q.push_back(wr_data);
      m_tail = (m_tail + 1) % DEPTH;
    end else if (wr_en) begin
      m_ovf = 1;
    end
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic w, logic [DW-1:0] d, logic r);
    wr_en = w; wr_data = d; rd_en = r;
    tick();
    wr_en = 0; rd_en = 0; rewind = 0; clear = 0;
  endtask

  task automatic do_reset(logic md);
    rst = 1; mode = md;
    drive(0, 8'h00, 0);
    rst = 0;
  endtask

  task automatic compare_model();
    check("rnd_rd_valid", 32'(rd_valid), 32'(m_rv));
    check("rnd_rd_data", 32'(rd_data), 32'(m_rd));
    check("rnd_count", 32'(count), 32'(m_q.size()));
    check("rnd_empty", 32'(empty), 32'(m_q.size() == 0));
    check("rnd_full", 32'(full), 32'(m_q.size() == DEPTH));
    check("rnd_overflow", 32'(overflow), 32'(m_ovf));
    check("rnd_underflow", 32'(underflow), 32'(m_unf));
    check("rnd_wr_ptr", 32'(wr_ptr_dbg), 32'(m_tail));
    check("rnd_rd_ptr", 32'(rd_ptr_dbg), 32'(m_mode ? (m_head + m_pos) % DEPTH : m_head));
  endtask

  typedef struct {
    logic          rst, wr, rd;
    logic [DW-1:0] wd;
    logic          ev;
    logic [DW-1:0] ed;
    int            ec;
    logic          efull, eempty, eovf, eunf;
    int            ewp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic w, logic [DW-1:0] d, logic rd, logic ev,
                              logic [DW-1:0] ed, int ec, logic ef, logic ee,
                              logic eo, logic eu, int ewp);
    vec_t v;
    v.rst = r; v.wr = w; v.wd = d; v.rd = rd; v.ev = ev; v.ed = ed; v.ec = ec;
    v.efull = ef; v.eempty = ee; v.eovf = eo; v.eunf = eu; v.ewp = ewp;
    vecs.push_back(v);
  endfunction

  initial begin
    // Fill, overflow, drain, underflow in FIFO mode.
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 1, 8'(8'h10 + i), 0, 0, 8'h00, i + 1, i == 7, 0, 0, 0, (i + 1) % 8);
    add(0, 1, 8'hFF, 0, 0, 8'h00, 8, 1, 0, 1, 0, 0);
    for (int k = 0; k < 8; k++)
      add(0, 0, 8'h00, 1, 1, 8'(8'h10 + k), 7 - k, 0, k == 7, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'h17, 0, 0, 1, 1, 1, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; mode = 0;
      drive(vecs[i].wr, vecs[i].wd, vecs[i].rd);
      check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].ed));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ec));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].efull));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].eempty));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].eovf));
      check($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].eunf));
      check($sformatf("vec%0d_wr_ptr", i), 32'(wr_ptr_dbg), 32'(vecs[i].ewp));
    end
    rst = 0;

    // Loop replay, rewind during a read, and extending the loop while playing.
    begin
      logic [DW-1:0] seq7[7];
      logic [DW-1:0] tail4[4];
      seq7  = '{8'hA0, 8'hA1, 8'hA2, 8'hA0, 8'hA1, 8'hA2, 8'hA0};
      tail4 = '{8'hA1, 8'hA2, 8'hA3, 8'hA0};
      do_reset(0);
      drive(1, 8'hA0, 0); drive(1, 8'hA1, 0); drive(1, 8'hA2, 0);
      mode = 1;
      drive(0, 8'h00, 0);
      for (int i = 0; i < 7; i++) begin
        drive(0, 8'h00, 1);
        check("loop_valid", 32'(rd_valid), 32'd1);
        check($sformatf("loop_data%0d", i), 32'(rd_data), 32'(seq7[i]));
      end
      check("loop_count", 32'(count), 32'd3);
      drive(0, 8'h00, 1);
      check("loop_pre_rewind", 32'(rd_data), 32'hA1);
      rewind = 1;
      drive(0, 8'h00, 1);
      check("loop_rewind_read", 32'(rd_data), 32'hA2);
      drive(0, 8'h00, 1);
      check("loop_after_rewind", 32'(rd_data), 32'hA0);
      for (int i = 0; i < 4; i++) begin
        drive(i == 0, 8'hA3, 1);
        check($sformatf("loop_ext%0d", i), 32'(rd_data), 32'(tail4[i]));
      end
      check("loop_ext_count", 32'(count), 32'd4);
    end

    // FIFO wrap past the RAM end, then loop replay across the boundary.
    begin
      logic [DW-1:0] rep[9];
      rep = '{8'h35, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h35, 8'h40};
      do_reset(0);
      for (int i = 0; i < 6; i++) drive(1, 8'(8'h30 + i), 0);
      for (int i = 0; i < 5; i++) begin
        drive(0, 8'h00, 1);
        check($sformatf("wrap_pop%0d", i), 32'(rd_data), 32'(8'h30 + i));
      end
      for (int i = 0; i < 6; i++) drive(1, 8'(8'h40 + i), 0);
      check("wrap_count", 32'(count), 32'd7);
      check("wrap_wr_ptr", 32'(wr_ptr_dbg), 32'd4);
      mode = 1;
      drive(0, 8'h00, 0);
      check("wrap_rd_ptr", 32'(rd_ptr_dbg), 32'd5);
      for (int i = 0; i < 9; i++) begin
        drive(0, 8'h00, 1);
        check($sformatf("wrap_loop%0d", i), 32'(rd_data), 32'(rep[i]));
      end
      check("wrap_loop_count", 32'(count), 32'd7);
    end

    // Full FIFO with simultaneous write+read, then clear with a write pending.
    do_reset(0);
    for (int i = 0; i < 8; i++) drive(1, 8'(8'h50 + i), 0);
    drive(1, 8'h99, 1);
    check("sim_valid", 32'(rd_valid), 32'd1);
    check("sim_data", 32'(rd_data), 32'h50);
    check("sim_overflow", 32'(overflow), 32'd1);
    check("sim_count", 32'(count), 32'd7);
    clear = 1;
    drive(1, 8'hEE, 1);
    check("clr_count", 32'(count), 32'd0);
    check("clr_overflow", 32'(overflow), 32'd0);
    check("clr_underflow", 32'(underflow), 32'd0);
    check("clr_valid", 32'(rd_valid), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    check("clr_wr_ptr", 32'(wr_ptr_dbg), 32'd0);
    drive(0, 8'h00, 1);
    check("clr_no_write_underflow", 32'(underflow), 32'd1);

    // Randomized traffic against the model, with bursty write/read bias.
    do_reset(0);
    compare_model();
    for (int blk = 0; blk < 30; blk++) begin
      int wp;
      wp = $urandom_range(15, 85);
      for (int c = 0; c < 60; c++) begin
        rst     = ($urandom_range(0, 299) == 0);
        clear   = ($urandom_range(0, 149) == 0);
        rewind  = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 39) == 0) mode = ~mode;
        wr_en   = ($urandom_range(0, 99) < wp);
        rd_en   = ($urandom_range(0, 99) >= wp);
        wr_data = 8'($urandom);
        tick();
        compare_model();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/loop_buffer_v2.md
Name: loop_buffer_v2

Overview:
- Parametrised successor to the single-channel record/loop sample buffer.
- Stores DATA_WIDTH-bit words in a DEPTH-entry RAM.
- Two read modes selected at run time:
  - FIFO mode: reads consume.
  - Loop mode: reads replay the stored contents cyclically without consuming.
- Adds a registered read port with a valid strobe, a soft clear, rewind, and sticky error flags. Sits between the sample capture path and the playback/UART streamer.

Parameters:
DATA_WIDTH, 8, word width in bits
DEPTH, 256, number of entries; must be a power of two, >= 2
ADDR_WIDTH, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
mode  in  1  0 = FIFO (consuming reads), 1 = loop (cyclic non-consuming reads)
clear  in  1  synchronous soft clear of pointers/count/flags; RAM contents untouched
rewind  in  1  loop mode: return play position to oldest entry
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write word
rd_en  in  1  read request
rd_data  out  DATA_WIDTH  registered read word
rd_valid  out  1  one-cycle strobe, rd_data valid
empty  out  1  count == 0 (combinational from count)
full  out  1  count == DEPTH (combinational from count)
count  out  ADDR_WIDTH+1  stored entries
overflow  out  1  sticky: wr_en seen while full
underflow  out  1  sticky: rd_en seen while empty
wr_ptr_dbg  out  ADDR_WIDTH  tail (next write address)
rd_ptr_dbg  out  ADDR_WIDTH  current read address (head in FIFO mode, head+play_off in loop mode)

Behaviour:
- Internal state:
  - head: oldest entry.
  - tail: next write address.
  - play_off: 0..count-1, loop offset.
  - count.
  - mode_q: registered mode.
- Pointers wrap modulo DEPTH naturally (power-of-two depth).
- Reset (rst=1):
  - head, tail, play_off, count, rd_data, rd_valid, overflow, underflow <= 0; mode_q <= mode.
  - empty=1, full=0 after reset. RAM not cleared.
- Priority: rst > clear > normal operation. clear has the same effect as rst on state; any wr_en/rd_en in that cycle is ignored (no write, no rd_valid).
- Write accepted iff wr_en && !full:
  - mem[tail] <= wr_data; tail+1.
  - count+1 unless a FIFO pop is accepted the same cycle.
- wr_en && full: word dropped, overflow <= 1.
- Read accepted iff rd_en && !empty, evaluated on pre-cycle count. rd_en && empty: underflow <= 1, rd_valid stays 0.
- Accepted read, FIFO mode (mode_q=0):
  - rd_data <= mem[head], rd_valid <= 1 next cycle; head+1; count-1 (net 0 if a write is accepted the same cycle).
  - Simultaneous write+read when full: read accepted, write rejected (full evaluated pre-cycle).
- Accepted read, loop mode (mode_q=1):
  - rd_data <= mem[head+play_off], rd_valid <= 1 next cycle; count unchanged.
  - play_off <= (play_off == count-1) ? 0 : play_off+1, using pre-cycle count; a same-cycle write extends the loop from the next cycle.
- Read latency: exactly 1 cycle, rd_en accept -> rd_valid high with data; back-to-back reads give back-to-back valids. rd_data holds its last value when rd_valid=0.
- Write-then-read same address same cycle: read returns the old RAM contents (read-before-write).
- rewind=1 (no rst/clear): play_off <= 0. If rd_en is also accepted in loop mode that cycle, the read uses the current play_off and play_off then becomes 0 (rewind wins over increment). No effect on head/tail/count.
- Mode change (mode != mode_q): mode_q <= mode and play_off <= 0. A read in that cycle uses the old mode_q.
- Loop mode wrap across the RAM boundary (head+play_off >= DEPTH) wraps modulo DEPTH.
- overflow/underflow clear only on rst or clear.

Test Plan:
- DEPTH=8, DATA_WIDTH=8. Reset, write 0x10..0x17 in FIFO mode -> count 0..8, full=1 after 8th; 9th write 0xFF dropped, overflow=1, tail=0.
- FIFO: after above, rd_en for 8 cycles -> rd_valid from cycle+1, data 0x10..0x17, empty=1 at end; extra rd_en -> underflow=1, no rd_valid.
- Loop: reset, write 0xA0,0xA1,0xA2, mode=1, rd_en for 7 cycles -> A0,A1,A2,A0,A1,A2,A0; count stays 3.
- Loop + rewind: mid-stream after A1 read, assert rewind with rd_en -> that read returns A2, next returns A0. Then write 0xA3 while looping -> sequence continues A1,A2,A3,A0.
- FIFO wrap: push 6, pop 5, push 6 (tail wraps) -> pops return pushes in order, count correct, wr_ptr_dbg=4. Switch to loop mode -> replays the 7 stored words from head across the RAM boundary.
- Simultaneous/clear:
  - full FIFO with wr_en+rd_en in the same cycle -> read valid, write dropped, overflow=1, count=7.
  - Then clear with wr_en asserted -> count=0, flags 0, no write.
